// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Instruction prefetch queue between the instruction memory
//               port and decode. It issues pipelined reads to an in-order,
//               variable-latency memory and buffers returned words with their
//               word-address PCs in a DEPTH-entry circular queue. A branch
//               redirect flushes the queue. Responses that are still in flight
//               when the branch is taken are counted and dropped when they
//               arrive.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : AW              word-address width of PC / memory address
//               DEPTH           queue entries (power of 2, >= 2)
//               MAX_OUTSTANDING accepted-but-unanswered read limit (>= 1)
//               RESET_PC        first word address fetched after reset
// Ports       : clk_i           clock
//               rst_ni          asynchronous active-low reset
//               stall_i         decode not accepting, head held
//               take_branch_i   redirect request
//               branch_pc_i     redirect target
//               valid_o         head entry valid
//               ir_o            head instruction
//               pc_o            head instruction word address
//               re_o            read request
//               rmemaddr_o      read address
//               rgnt_i          memory accepts request this cycle
//               rmemack_i       in-order response valid
//               rmemdata_i      response data
// Option      : FETCH_PERF_EN   adds perf_fetched_o / perf_dropped_o counters
// ============================================================================
module fetch_prefetch_queue #(
    parameter int              AW              = 30,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 4,
    parameter logic [AW-1:0]   RESET_PC        = '0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               stall_i,
    input  logic               take_branch_i,
    input  logic [AW-1:0]      branch_pc_i,
    output logic               valid_o,
    output logic [31:0]        ir_o,
    output logic [AW-1:0]      pc_o,
    output logic               re_o,
    output logic [AW-1:0]      rmemaddr_o,
    input  logic               rgnt_i,
    input  logic               rmemack_i,
    input  logic [31:0]        rmemdata_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_dropped_o
`endif
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam int c_OW = $clog2(MAX_OUTSTANDING + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]   r_fetch_pc;
    logic [AW-1:0]   r_resp_pc;
    logic [c_CW-1:0] r_count;
    logic [c_OW-1:0] r_outstanding;
    logic [c_OW-1:0] r_drop_cnt;
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [31:0]     r_ir_q [DEPTH];
    logic [AW-1:0]   r_pc_q [DEPTH];

    logic [31:0]     w_inflight;
    logic            w_re;
    logic            w_grant;
    logic            w_ack_ok;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_valid;

    // ------------------------------------------------------------------
    // Issue / consume decode
    // ------------------------------------------------------------------
    // Queue slots already filled plus reads still in flight form the credit
    // that bounds issue, so a response always finds a free slot.
    assign w_inflight = 32'(r_count) + 32'(r_outstanding);

    // Gating with rst_ni keeps the request low while reset is asserted.
    assign w_re     = rst_ni && !take_branch_i
                   && (w_inflight < 32'(DEPTH))
                   && (32'(r_outstanding) < 32'(MAX_OUTSTANDING));
    assign w_grant  = w_re && rgnt_i;

    // An ack with nothing outstanding is a protocol error and is ignored.
    assign w_ack_ok = rmemack_i && (r_outstanding != '0);
    assign w_drop   = w_ack_ok && !take_branch_i && (r_drop_cnt != '0);
    assign w_push   = w_ack_ok && !take_branch_i && (r_drop_cnt == '0);

    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && !stall_i && !take_branch_i;

    assign re_o       = w_re;
    assign rmemaddr_o = r_fetch_pc;
    assign valid_o    = w_valid;
    assign ir_o       = r_ir_q[r_rd_ptr];
    assign pc_o       = r_pc_q[r_rd_ptr];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (take_branch_i) begin
            // Flush: everything still in flight, minus a same-cycle ack
            // which is discarded here, must be dropped when it returns.
            // The validated ack is used so a stray ack cannot underflow.
            r_fetch_pc    <= branch_pc_i;
            r_resp_pc     <= branch_pc_i;
            r_count       <= '0;
            r_rd_ptr      <= r_wr_ptr;
            r_outstanding <= r_outstanding - c_OW'(w_ack_ok);
            r_drop_cnt    <= r_outstanding - c_OW'(w_ack_ok);
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + AW'(1);
            end
            r_outstanding <= r_outstanding + c_OW'(w_grant) - c_OW'(w_ack_ok);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - c_OW'(1);
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + c_PW'(1);
                r_resp_pc <= r_resp_pc + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (contents are don't-care until written)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_ir_q[r_wr_ptr] <= rmemdata_i;
            r_pc_q[r_wr_ptr] <= r_resp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] w_dropped_inc;

    // Dropped work: discarded responses (drop counter or same-cycle branch
    // ack) plus every entry flushed from the queue on a branch.
    assign w_dropped_inc = take_branch_i
                         ? (32'(r_count) + 32'(w_ack_ok))
                         : 32'(w_drop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 32'(w_grant);
            r_perf_dropped <= r_perf_dropped + w_dropped_inc;
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_dropped_o = r_perf_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_queue
// Description : Self-checking bench for fetch_prefetch_queue: a directed
//               vector table with fully hand-driven memory signals, followed
//               by hand-written sequences using a small in-order memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    localparam int AW = 30;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          stall_i;
    logic          take_branch_i;
    logic [AW-1:0] branch_pc_i;
    logic          valid_o;
    logic [31:0]   ir_o;
    logic [AW-1:0] pc_o;
    logic          re_o;
    logic [AW-1:0] rmemaddr_o;
    logic          rgnt_i;
    logic          rmemack_i;
    logic [31:0]   rmemdata_i;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched_o;
    logic [31:0]   perf_dropped_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_prefetch_queue #(
        .AW              (AW),
        .DEPTH           (4),
        .MAX_OUTSTANDING (4),
        .RESET_PC        ('0)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .take_branch_i (take_branch_i),
        .branch_pc_i   (branch_pc_i),
        .valid_o       (valid_o),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .re_o          (re_o),
        .rmemaddr_o    (rmemaddr_o),
        .rgnt_i        (rgnt_i),
        .rmemack_i     (rmemack_i),
        .rmemdata_i    (rmemdata_i)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o(perf_fetched_o),
        .perf_dropped_o(perf_dropped_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory contents as a function of word address.
    function automatic logic [31:0] memd(input logic [AW-1:0] a);
        return {2'b10, a} ^ 32'h0F0F_0F0F;
    endfunction

    // ------------------------------------------------------------------
    // In-order memory model for the hand-written sequences
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } req_t;

    req_t mq[$];
    int   cyc_n;
    int   lat;
    int   grants;
    int   acks_del;
    int   pops;

    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            rmemack_i  = 1'b1;
            rmemdata_i = memd(mq[0].addr);
            void'(mq.pop_front());
            acks_del++;
        end else begin
            rmemack_i  = 1'b0;
            rmemdata_i = '0;
        end
    endtask

    task automatic mem_clock();
        if (re_o && rgnt_i) begin
            mq.push_back('{rmemaddr_o, cyc_n + lat});
            grants++;
        end
        if (valid_o && !stall_i && !take_branch_i) pops++;
        @(posedge clk_i);
        cyc_n++;
        @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        take_branch_i = 1'b0;
        branch_pc_i   = '0;
        rgnt_i        = 1'b0;
        rmemack_i     = 1'b0;
        rmemdata_i    = '0;
        mq.delete();
        cyc_n    = 0;
        grants   = 0;
        acks_del = 0;
        pops     = 0;
        repeat (2) @(negedge clk_i);
        #1;
        chk({tag, "_rst_valid"}, valid_o, 0);
        chk({tag, "_rst_re"}, re_o, 0);
`ifdef FETCH_PERF_EN
        chk({tag, "_rst_perf_f"}, perf_fetched_o, 0);
        chk({tag, "_rst_perf_d"}, perf_dropped_o, 0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          st;
        logic          br;
        logic [AW-1:0] bpc;
        logic          gnt;
        logic          ack;
        logic [31:0]   data;
        logic          e_valid;
        logic [AW-1:0] e_pc;
        logic [31:0]   e_ir;
        logic          e_re;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic br, input logic [AW-1:0] bpc,
                                input logic gnt, input logic ack, input logic [31:0] data,
                                input logic ev, input logic [AW-1:0] ep, input logic [31:0] ei,
                                input logic er, input logic [AW-1:0] ea);
        vec_t v;
        v.st = st; v.br = br; v.bpc = bpc; v.gnt = gnt; v.ack = ack; v.data = data;
        v.e_valid = ev; v.e_pc = ep; v.e_ir = ei; v.e_re = er; v.e_addr = ea;
        return v;
    endfunction

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int            found;
        int            queued;
        int            seen;
        int            next_pc;

        //           st br bpc      g  a  data              ev ep       ei                re ea
        tbl[0]  = mk(0, 0, 30'h0,   0, 0, 32'h0,            0, 30'h0,   32'h0,            1, 30'h0);
        tbl[1]  = mk(0, 0, 30'h0,   1, 0, 32'h0,            0, 30'h0,   32'h0,            1, 30'h0);
        tbl[2]  = mk(0, 0, 30'h0,   1, 1, memd(30'h0),      0, 30'h0,   32'h0,            1, 30'h1);
        tbl[3]  = mk(0, 0, 30'h0,   1, 1, memd(30'h1),      1, 30'h0,   memd(30'h0),      1, 30'h2);
        tbl[4]  = mk(1, 0, 30'h0,   1, 1, memd(30'h2),      1, 30'h1,   memd(30'h1),      1, 30'h3);
        tbl[5]  = mk(1, 0, 30'h0,   1, 1, memd(30'h3),      1, 30'h1,   memd(30'h1),      1, 30'h4);
        tbl[6]  = mk(1, 0, 30'h0,   1, 0, 32'h0,            1, 30'h1,   memd(30'h1),      0, 30'h5);
        tbl[7]  = mk(1, 0, 30'h0,   1, 1, memd(30'h4),      1, 30'h1,   memd(30'h1),      0, 30'h5);
        tbl[8]  = mk(1, 0, 30'h0,   1, 0, 32'h0,            1, 30'h1,   memd(30'h1),      0, 30'h5);
        tbl[9]  = mk(0, 0, 30'h0,   1, 0, 32'h0,            1, 30'h1,   memd(30'h1),      0, 30'h5);
        tbl[10] = mk(0, 0, 30'h0,   1, 0, 32'h0,            1, 30'h2,   memd(30'h2),      1, 30'h5);
        tbl[11] = mk(0, 0, 30'h0,   0, 0, 32'h0,            1, 30'h3,   memd(30'h3),      1, 30'h6);
        tbl[12] = mk(0, 0, 30'h0,   0, 0, 32'h0,            1, 30'h4,   memd(30'h4),      1, 30'h6);
        tbl[13] = mk(0, 1, 30'h100, 1, 1, 32'hBADB_AD00,    0, 30'h0,   32'h0,            0, 30'h6);
        tbl[14] = mk(0, 0, 30'h0,   1, 0, 32'h0,            0, 30'h0,   32'h0,            1, 30'h100);
        tbl[15] = mk(0, 0, 30'h0,   0, 1, memd(30'h100),    0, 30'h0,   32'h0,            1, 30'h101);
        tbl[16] = mk(1, 0, 30'h0,   0, 1, 32'h0BAD_0BAD,    1, 30'h100, memd(30'h100),    1, 30'h101);
        tbl[17] = mk(0, 0, 30'h0,   0, 0, 32'h0,            1, 30'h100, memd(30'h100),    1, 30'h101);
        tbl[18] = mk(0, 0, 30'h0,   0, 0, 32'h0,            0, 30'h0,   32'h0,            1, 30'h101);

        // ---------------- table-driven vectors ----------------
        do_reset("T");
        for (int i = 0; i < NV; i++) begin
            stall_i       = tbl[i].st;
            take_branch_i = tbl[i].br;
            branch_pc_i   = tbl[i].bpc;
            rgnt_i        = tbl[i].gnt;
            rmemack_i     = tbl[i].ack;
            rmemdata_i    = tbl[i].data;
            #1;
            chk($sformatf("T%0d_valid", i), valid_o, tbl[i].e_valid);
            chk($sformatf("T%0d_re", i), re_o, tbl[i].e_re);
            chk($sformatf("T%0d_addr", i), rmemaddr_o, tbl[i].e_addr);
            if (tbl[i].e_valid) begin
                chk($sformatf("T%0d_pc", i), pc_o, tbl[i].e_pc);
                chk($sformatf("T%0d_ir", i), ir_o, tbl[i].e_ir);
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end

        // ---------------- streaming, latency 1 ----------------
        do_reset("A");
        lat    = 1;
        rgnt_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_drive();
            #1;
            chk("A_re", re_o, 1);
            chk("A_addr", rmemaddr_o, 32'(k));
            chk("A_valid", valid_o, (k >= 2));
            if (k >= 2) begin
                chk("A_pc", pc_o, 32'(k - 2));
                chk("A_ir", ir_o, memd(AW'(k - 2)));
            end
            mem_clock();
        end

        // ---------------- stall fills the queue ----------------
        do_reset("S");
        lat     = 1;
        rgnt_i  = 1'b1;
        stall_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_drive();
            #1;
            chk("S_re", re_o, (k < 4));
            chk("S_valid", valid_o, (k >= 2));
            if (valid_o) chk("S_head_pc", pc_o, 0);
            mem_clock();
        end
        chk("S_grants", grants, 4);
        stall_i = 1'b0;
        next_pc = 0;
        for (int k = 0; k < 12; k++) begin
            mem_drive();
            #1;
            if (valid_o) begin
                chk("S_pc", pc_o, 32'(next_pc));
                chk("S_ir", ir_o, memd(AW'(next_pc)));
                next_pc++;
            end
            mem_clock();
        end
        chk("S_streamed", next_pc, 12);

        // ---------------- grant withheld ----------------
        do_reset("G");
        lat    = 1;
        rgnt_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            mem_drive();
            #1;
            chk("G_re", re_o, 1);
            chk("G_addr_hold", rmemaddr_o, 0);
            mem_clock();
        end
        rgnt_i = 1'b1;
        mem_drive();
        #1;
        chk("G_addr_gnt", rmemaddr_o, 0);
        mem_clock();
        mem_drive();
        #1;
        chk("G_addr_next", rmemaddr_o, 1);
        mem_clock();

        // ---------------- branch with 3 reads in flight ----------------
        do_reset("B");
        lat    = 3;
        rgnt_i = 1'b1;
        found  = 0;
        for (int it = 0; it < 40 && found == 0; it++) begin
            if (mq.size() == 3) begin
                if (mq[0].addr == 5 && mq[1].addr == 6 && mq[2].addr == 7) found = 1;
            end
            if (found == 0) begin
                mem_drive();
                #1;
                mem_clock();
            end
        end
        chk("B_setup", found, 1);
        queued        = acks_del - pops;
        take_branch_i = 1'b1;
        branch_pc_i   = 30'h100;
        mem_drive();
        #1;
        chk("B_re_branch", re_o, 0);
        mem_clock();
        take_branch_i = 1'b0;
        mem_drive();
        #1;
        chk("B_addr_target", rmemaddr_o, 32'h100);
        chk("B_flushed", valid_o, 0);
        mem_clock();
        seen = 0;
        for (int it = 0; it < 30 && seen == 0; it++) begin
            mem_drive();
            #1;
            if (valid_o) begin
                seen = 1;
                chk("B_pc", pc_o, 32'h100);
                chk("B_ir", ir_o, memd(30'h100));
`ifdef FETCH_PERF_EN
                chk("B_perf_dropped", perf_dropped_o, 32'(3 + queued));
                chk("B_perf_fetched", perf_fetched_o, 32'(grants));
`endif
            end
            mem_clock();
        end
        chk("B_seen", seen, 1);

        // ---------------- branch with same-cycle ack and pop ----------------
        do_reset("C");
        lat    = 2;
        rgnt_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mem_drive();
            #1;
            mem_clock();
        end
        take_branch_i = 1'b1;
        branch_pc_i   = 30'h40;
        mem_drive();
        #1;
        chk("C_valid_pre", valid_o, 1);
        chk("C_re_branch", re_o, 0);
        mem_clock();
        take_branch_i = 1'b0;
        mem_drive();
        #1;
        chk("C_flushed", valid_o, 0);
        chk("C_re_after", re_o, 1);
        chk("C_addr_target", rmemaddr_o, 32'h40);
        mem_clock();
        seen = 0;
        for (int it = 0; it < 20 && seen == 0; it++) begin
            mem_drive();
            #1;
            if (valid_o) begin
                seen = 1;
                chk("C_pc", pc_o, 32'h40);
                chk("C_ir", ir_o, memd(30'h40));
            end
            mem_clock();
        end
        chk("C_seen", seen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
